// File: rtl/ps2mouse_cmd_seq_if.sv
// Byte-level PS/2 transceiver, user command and stream packet signals of the mouse sequencer.
interface ps2mouse_cmd_seq_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] user_cmd;
   logic       user_req;
   logic       user_ack;
   logic [7:0] user_resp;
   logic       user_resp_valid;
   logic [7:0] pkt_byte;
   logic [1:0] pkt_idx;
   logic       pkt_valid;
   logic       wheel;
   logic       ready;
   logic       fail;

   modport master (
      output tx_data, tx_valid, user_ack, user_resp, user_resp_valid,
             pkt_byte, pkt_idx, pkt_valid, wheel, ready, fail,
      input  tx_ready, rx_data, rx_valid, user_cmd, user_req
   );

   modport slave (
      input  tx_data, tx_valid, user_ack, user_resp, user_resp_valid,
             pkt_byte, pkt_idx, pkt_valid, wheel, ready, fail,
      output tx_ready, rx_data, rx_valid, user_cmd, user_req
   );
endinterface

// File: rtl/ps2mouse_cmd_seq.sv
// PS/2 mouse init script, IntelliMouse detection, stream packet framing and user command injection.
// All rx-driven outputs lag rx_valid by one cycle; tx_valid is held until tx_ready, rx has no backpressure.
module ps2mouse_cmd_seq #(
   parameter int unsigned c_timeout = 2000000,
   parameter int unsigned c_gap     = 100000,
   parameter int unsigned c_retries = 3
) (
   input  logic               clk,
   input  logic               reset,
   ps2mouse_cmd_seq_if.master bus
);
   typedef enum logic [2:0] {INIT_SEND, INIT_WAIT, STREAM, USER_SEND, USER_WAIT, FAIL} state_t;

   localparam logic [4:0] last_step = 5'd20;

   state_t      state, state_n;
   logic [4:0]  step, send_step;
   logic [1:0]  resend_cnt, pkt_cnt, last_idx;
   logic [31:0] retry_cnt, timer;
   logic [9:0]  info, next_info;
   logic        hs, tmo, timing, gap_fire;
   logic        init_ok, init_resend, init_fail, grant;

   logic        tx_valid_q, user_ack_q, user_resp_valid_q, pkt_valid_q, wheel_q;
   logic [7:0]  tx_data_q, user_cmd_q, user_resp_q, pkt_byte_q;
   logic [1:0]  pkt_idx_q;

   // Script entry: {is_send, accept_any_byte, byte}
   function automatic logic [9:0] step_info(input logic [4:0] s);
      case (s)
         5'd0:    step_info = {2'b10, 8'hFF};
         5'd2:    step_info = {2'b00, 8'hAA};
         5'd3:    step_info = {2'b00, 8'h00};
         5'd4:    step_info = {2'b10, 8'hF3};
         5'd6:    step_info = {2'b10, 8'hC8};
         5'd8:    step_info = {2'b10, 8'hF3};
         5'd10:   step_info = {2'b10, 8'h64};
         5'd12:   step_info = {2'b10, 8'hF3};
         5'd14:   step_info = {2'b10, 8'h50};
         5'd16:   step_info = {2'b10, 8'hF2};
         5'd18:   step_info = {2'b01, 8'h03};
         5'd19:   step_info = {2'b10, 8'hF4};
         default: step_info = {2'b00, 8'hFA};
      endcase
   endfunction

   assign info      = step_info(step);
   assign next_info = step_info(step + 5'd1);
   assign hs        = tx_valid_q & bus.tx_ready;
   assign tmo       = (timer == c_timeout - 32'd1);
   assign last_idx  = wheel_q ? 2'd3 : 2'd2;
   assign timing    = (state == INIT_WAIT) || (state == USER_WAIT) ||
                      ((state == STREAM) && (pkt_cnt != 2'd0));
   assign gap_fire  = (state == STREAM) && (pkt_cnt != 2'd0) && !bus.rx_valid &&
                      (timer == c_gap - 32'd1);

   always_ff @(posedge clk) begin
      if (reset) state <= INIT_SEND;
      else       state <= state_n;
   end

   always_comb begin
      state_n     = state;
      init_ok     = 1'b0;
      init_resend = 1'b0;
      init_fail   = 1'b0;
      grant       = 1'b0;
      case (state)
         INIT_SEND: if (hs) state_n = INIT_WAIT;
         INIT_WAIT: begin
            if (bus.rx_valid) begin
               if (info[8] || (bus.rx_data == info[7:0]))         init_ok     = 1'b1;
               else if (bus.rx_data == 8'hFE && resend_cnt != 2'd2) init_resend = 1'b1;
               else                                               init_fail   = 1'b1;
            end else if (tmo) begin
               init_fail = 1'b1;
            end
            if (init_ok) begin
               if (step == last_step)  state_n = STREAM;
               else if (next_info[9])  state_n = INIT_SEND;
            end else if (init_resend) begin
               state_n = INIT_SEND;
            end else if (init_fail) begin
               state_n = (retry_cnt + 32'd1 >= c_retries) ? FAIL : INIT_SEND;
            end
         end
         STREAM: begin
            // A stream byte in the same cycle always wins over the requester.
            if (bus.user_req && pkt_cnt == 2'd0 && !bus.rx_valid) begin
               grant   = 1'b1;
               state_n = USER_SEND;
            end
         end
         USER_SEND: if (hs) state_n = USER_WAIT;
         USER_WAIT: if (bus.rx_valid || tmo) state_n = STREAM;
         FAIL:      state_n = FAIL;
         default:   state_n = INIT_SEND;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step              <= 5'd0;
         send_step         <= 5'd0;
         resend_cnt        <= 2'd0;
         retry_cnt         <= 32'd0;
         timer             <= 32'd0;
         pkt_cnt           <= 2'd0;
         tx_valid_q        <= 1'b0;
         tx_data_q         <= 8'h00;
         user_cmd_q        <= 8'h00;
         user_ack_q        <= 1'b0;
         user_resp_q       <= 8'h00;
         user_resp_valid_q <= 1'b0;
         pkt_byte_q        <= 8'h00;
         pkt_idx_q         <= 2'd0;
         pkt_valid_q       <= 1'b0;
         wheel_q           <= 1'b0;
      end else begin
         user_ack_q        <= grant;
         user_resp_valid_q <= 1'b0;
         pkt_valid_q       <= 1'b0;

         // tx_valid rises one cycle after a send state is entered and drops on the handshake.
         tx_valid_q <= ((state == INIT_SEND) || (state == USER_SEND)) && !hs;
         if (!tx_valid_q && state == INIT_SEND) tx_data_q <= info[7:0];
         if (!tx_valid_q && state == USER_SEND) tx_data_q <= user_cmd_q;

         if (!timing || hs || bus.rx_valid || gap_fire) timer <= 32'd0;
         else                                          timer <= timer + 32'd1;

         if (state == INIT_SEND && hs) begin
            send_step <= step;
            step      <= step + 5'd1;
         end
         if (init_ok) begin
            if (info[8])      wheel_q    <= (bus.rx_data == 8'h03);
            if (next_info[9]) resend_cnt <= 2'd0;
            if (step != last_step) step  <= step + 5'd1;
         end
         if (init_resend) begin
            step       <= send_step;
            resend_cnt <= resend_cnt + 2'd1;
         end
         if (init_fail) begin
            step       <= 5'd0;
            resend_cnt <= 2'd0;
            retry_cnt  <= retry_cnt + 32'd1;
         end

         if (grant) user_cmd_q <= bus.user_cmd;
         if (state == USER_WAIT && (bus.rx_valid || tmo)) begin
            user_resp_q       <= bus.rx_valid ? bus.rx_data : 8'h00;
            user_resp_valid_q <= 1'b1;
         end

         if (state == STREAM && bus.rx_valid) begin
            // First byte of every packet carries bit 3 set; anything else means we are out of sync.
            if (pkt_cnt != 2'd0 || bus.rx_data[3]) begin
               pkt_byte_q  <= bus.rx_data;
               pkt_idx_q   <= pkt_cnt;
               pkt_valid_q <= 1'b1;
               pkt_cnt     <= (pkt_cnt == last_idx) ? 2'd0 : pkt_cnt + 2'd1;
            end
         end else if (gap_fire) begin
            pkt_cnt <= 2'd0;
         end
      end
   end

   assign bus.tx_data         = tx_data_q;
   assign bus.tx_valid        = tx_valid_q;
   assign bus.user_ack        = user_ack_q;
   assign bus.user_resp       = user_resp_q;
   assign bus.user_resp_valid = user_resp_valid_q;
   assign bus.pkt_byte        = pkt_byte_q;
   assign bus.pkt_idx         = pkt_idx_q;
   assign bus.pkt_valid       = pkt_valid_q;
   assign bus.wheel           = wheel_q;
   assign bus.ready           = (state == STREAM) || (state == USER_SEND) || (state == USER_WAIT);
   assign bus.fail            = (state == FAIL);
endmodule

// File: tb/tb_ps2mouse_cmd_seq.sv
// Directed bench for ps2mouse_cmd_seq: init script tables, stream framing tables and user/reset corner sequences.
module tb_ps2mouse_cmd_seq;
   localparam int unsigned tmo_cyc = 200;
   localparam int unsigned gap_cyc = 50;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ps2mouse_cmd_seq_if bus ();

   ps2mouse_cmd_seq #(.c_timeout(tmo_cyc), .c_gap(gap_cyc), .c_retries(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] tx; int n; logic [7:0] r0; logic [7:0] r1; logic [7:0] r2; } xchg_t;
   typedef struct { logic [7:0] rx; logic vld; logic [1:0] idx; } svec_t;

   xchg_t init_tbl [9];
   svec_t stab [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic expect_tx(input logic [7:0] b, input string name);
      int n = 0;
      while (bus.tx_valid !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (bus.tx_valid !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: tx_valid never rose, want tx 0x%0h", name, b);
      end else begin
         check(name, bus.tx_data, b);
         bus.tx_ready = 1'b1;
         @(negedge clk);
         bus.tx_ready = 1'b0;
         check({name, "_drop"}, bus.tx_valid, 0);
      end
   endtask

   task automatic wait_ack(input string name);
      int n = 0;
      while (bus.user_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, bus.user_ack, 1);
   endtask

   task automatic apply_reset();
      reset        = 1'b1;
      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.user_req = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_init(input logic [7:0] id, input int fe_at);
      logic [7:0] r [3];
      for (int i = 0; i < 9; i++) begin
         r[0] = init_tbl[i].r0;
         r[1] = (init_tbl[i].tx == 8'hF2) ? id : init_tbl[i].r1;
         r[2] = init_tbl[i].r2;
         expect_tx(init_tbl[i].tx, "init_tx");
         if (i == fe_at) begin
            send_rx(8'hFE);
            expect_tx(init_tbl[i].tx, "resend_tx");
         end
         if (i == 8) check("ready_before_last_ack", bus.ready, 0);
         for (int k = 0; k < init_tbl[i].n; k++) send_rx(r[k]);
      end
      check("ready_after_init", bus.ready, 1);
      check("wheel_after_init", bus.wheel, (id == 8'h03) ? 1 : 0);
   endtask

   task automatic run_stream(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         send_rx(stab[i].rx);
         check("pkt_valid", bus.pkt_valid, stab[i].vld);
         if (stab[i].vld) begin
            check("pkt_idx", bus.pkt_idx, stab[i].idx);
            check("pkt_byte", bus.pkt_byte, stab[i].rx);
         end
      end
   endtask

   initial begin
      int n;
      logic seen;
      init_tbl[0] = '{8'hFF, 3, 8'hFA, 8'hAA, 8'h00};
      init_tbl[1] = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
      init_tbl[2] = '{8'hC8, 1, 8'hFA, 8'h00, 8'h00};
      init_tbl[3] = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
      init_tbl[4] = '{8'h64, 1, 8'hFA, 8'h00, 8'h00};
      init_tbl[5] = '{8'hF3, 1, 8'hFA, 8'h00, 8'h00};
      init_tbl[6] = '{8'h50, 1, 8'hFA, 8'h00, 8'h00};
      init_tbl[7] = '{8'hF2, 2, 8'hFA, 8'h00, 8'h00};
      init_tbl[8] = '{8'hF4, 1, 8'hFA, 8'h00, 8'h00};
      // standard mouse packets, then resync drop
      stab[0] = '{8'h08, 1'b1, 2'd0};
      stab[1] = '{8'h05, 1'b1, 2'd1};
      stab[2] = '{8'hFB, 1'b1, 2'd2};
      stab[3] = '{8'h00, 1'b0, 2'd0};
      // wheel mouse: four-byte packets
      stab[4] = '{8'h09, 1'b1, 2'd0};
      stab[5] = '{8'h01, 1'b1, 2'd1};
      stab[6] = '{8'h02, 1'b1, 2'd2};
      stab[7] = '{8'hFF, 1'b1, 2'd3};
      stab[8] = '{8'h08, 1'b1, 2'd0};

      bus.tx_ready = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.user_req = 1'b0;
      bus.user_cmd = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_tx_valid", bus.tx_valid, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_ready", bus.ready, 0);
      check("rst_fail", bus.fail, 0);
      check("rst_wheel", bus.wheel, 0);
      check("rst_pkt_valid", bus.pkt_valid, 0);
      check("rst_user_ack", bus.user_ack, 0);
      check("rst_user_resp_valid", bus.user_resp_valid, 0);
      reset = 1'b0;

      // Standard mouse
      run_init(8'h00, -1);
      run_stream(0, 3);

      // Gap resync
      send_rx(8'h08);
      check("gap_first_idx", bus.pkt_idx, 0);
      repeat (gap_cyc + 10) @(negedge clk);
      send_rx(8'h18);
      check("gap_pkt_valid", bus.pkt_valid, 1);
      check("gap_pkt_idx", bus.pkt_idx, 0);
      repeat (gap_cyc + 10) @(negedge clk);

      // User request raised with a stream byte: byte wins, then no grant mid-packet
      bus.user_cmd = 8'hE9;
      bus.user_req = 1'b1;
      send_rx(8'h08);
      check("rxwin_ack", bus.user_ack, 0);
      check("rxwin_pkt_valid", bus.pkt_valid, 1);
      send_rx(8'h05);
      check("midpkt_ack1", bus.user_ack, 0);
      send_rx(8'hFB);
      check("midpkt_ack2", bus.user_ack, 0);
      check("midpkt_last_idx", bus.pkt_idx, 2);
      wait_ack("user_ack_grant");
      bus.user_req = 1'b0;
      expect_tx(8'hE9, "user_tx");
      send_rx(8'hFA);
      check("user_resp_valid", bus.user_resp_valid, 1);
      check("user_resp", bus.user_resp, 8'hFA);
      check("user_resp_no_pkt", bus.pkt_valid, 0);
      check("user_ready_kept", bus.ready, 1);

      // User reply timeout
      bus.user_cmd = 8'hF2;
      bus.user_req = 1'b1;
      wait_ack("user_ack_tmo");
      bus.user_req = 1'b0;
      expect_tx(8'hF2, "user_tx_tmo");
      n = 0;
      while (bus.user_resp_valid !== 1'b1 && n < int'(tmo_cyc) + 20) begin
         @(negedge clk);
         n++;
      end
      check("tmo_resp_valid", bus.user_resp_valid, 1);
      check("tmo_resp", bus.user_resp, 8'h00);

      // Reset during USER_SEND restarts the script
      bus.user_cmd = 8'hE9;
      bus.user_req = 1'b1;
      wait_ack("user_ack_rst");
      bus.user_req = 1'b0;
      @(negedge clk);
      check("user_send_tx_valid", bus.tx_valid, 1);
      check("user_send_tx_data", bus.tx_data, 8'hE9);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_tx_valid", bus.tx_valid, 0);
      check("rst_mid_ready", bus.ready, 0);
      reset = 1'b0;

      // Wheel mouse
      run_init(8'h03, -1);
      run_stream(4, 8);

      // Single FE to the second F3 is absorbed by one resend
      apply_reset();
      run_init(8'h00, 3);

      // Third FE on the same byte abandons the attempt and restarts at FF
      apply_reset();
      expect_tx(8'hFF, "fe3_ff");
      send_rx(8'hFA);
      send_rx(8'hAA);
      send_rx(8'h00);
      expect_tx(8'hF3, "fe3_f3");
      send_rx(8'hFA);
      expect_tx(8'hC8, "fe3_c8");
      send_rx(8'hFE);
      expect_tx(8'hC8, "fe3_c8_resend1");
      send_rx(8'hFE);
      expect_tx(8'hC8, "fe3_c8_resend2");
      send_rx(8'hFE);
      expect_tx(8'hFF, "fe3_restart");

      // Silent mouse: three timed-out attempts then FAIL
      apply_reset();
      for (int a = 0; a < 3; a++) expect_tx(8'hFF, "silent_ff");
      check("silent_not_failed_yet", bus.fail, 0);
      n = 0;
      while (bus.fail !== 1'b1 && n < int'(tmo_cyc) + 20) begin
         @(negedge clk);
         n++;
      end
      check("silent_fail", bus.fail, 1);
      check("silent_ready", bus.ready, 0);
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         seen = seen | bus.tx_valid;
      end
      check("silent_tx_quiet", seen, 0);
      check("silent_fail_held", bus.fail, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ps2mouse_cmd_seq.md
# ps2mouse_cmd_seq

Command sequencer and arbiter for the PS/2 mouse port. It drives a byte-level PS/2 host transceiver through a ready/valid transmit handshake and a strobed receive path. After reset it runs the mouse initialisation script, including IntelliMouse wheel detection, then frames stream bytes into 3- or 4-byte packets for the mouse decoder. It also lets one user requester inject single-byte commands at packet boundaries.

## Interface
- c_timeout, default 2000000: clk cycles allowed for any expected response byte before the attempt is declared failed.
- c_gap, default 100000: clk cycles of silence after which a partial stream packet is discarded.
- c_retries, default 3: full init restarts allowed before `fail`.

Ports (clock and reset first):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- tx_data  out  8  command byte to transceiver
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transceiver accepts tx_data this cycle
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- user_cmd  in  8  user command byte
- user_req  in  1  user request; level, held until user_ack
- user_ack  out  1  one-cycle pulse, user_cmd accepted for sending
- user_resp  out  8  mouse reply to the user command
- user_resp_valid  out  1  one-cycle strobe
- pkt_byte  out  8  stream packet byte
- pkt_idx  out  2  index of pkt_byte within its packet (0..3)
- pkt_valid  out  1  one-cycle strobe
- wheel  out  1  device ID 0x03 detected
- ready  out  1  init done, streaming
- fail  out  1  init abandoned after c_retries restarts

## Operation
- Reset values: all outputs 0; retry count 0; step index 0; state INIT_SEND.
- Init script, in order, with the reply expected after each byte:
  - 0xFF: expect 0xFA, then 0xAA, then 0x00.
  - 0xF3 0xC8, 0xF3 0x64, 0xF3 0x50: expect 0xFA after every byte.
  - 0xF2: expect 0xFA, then an ID byte. ID 0x03 sets `wheel`=1; any other ID sets `wheel`=0.
  - 0xF4: expect 0xFA.
- States:
  - INIT_SEND: tx_valid=1 and tx_data is the step byte. On tx_ready, go to INIT_WAIT and clear the timer.
  - INIT_WAIT: on each rx_valid, compare rx_data with the expected byte.
    - Match: advance. The next step is either another expected reply (stay) or a send (INIT_SEND).
    - 0xFE: resend the same command byte, at most 2 times per byte. The third 0xFE counts as a failure.
    - Any other mismatch, or the timer reaching c_timeout: failure.
  - Failure handling: increment the retry count and restart at step 0. When the count reaches c_retries, go to FAIL.
  - STREAM: ready=1.
    - Each rx_valid produces one pkt_byte and pkt_idx, then pkt_idx increments. pkt_idx wraps after 2 (wheel=0) or 3 (wheel=1).
    - When pkt_idx=0, a byte with bit 3 = 0 is dropped (resync) and produces no pkt_valid.
    - c_gap cycles without rx_valid while pkt_idx≠0 resets pkt_idx to 0.
  - User arbitration, in STREAM only:
    - A request is granted only when pkt_idx=0 and no rx_valid arrives in the same cycle. rx_valid wins any simultaneous event.
    - On grant, pulse user_ack and go to USER_SEND. Then tx_valid until tx_ready, then USER_WAIT.
    - In USER_WAIT, the first rx byte is reported as user_resp/user_resp_valid, then return to STREAM. Reply bytes are never forwarded as pkt_valid.
    - A USER_WAIT timeout returns to STREAM with user_resp=0x00, user_resp_valid=1.
  - FAIL: sink state. Only reset leaves it. tx_valid=0, ready=0, fail=1.
- Reset mid-operation: immediate abort. tx_valid drops the next cycle, and the script restarts from 0xFF with the retry count cleared.

## Timing
- tx_valid is asserted the cycle after entering a send state. tx_data is stable while tx_valid=1. tx_valid deasserts the cycle after the tx_ready handshake.
- pkt_valid, user_resp_valid and all rx-driven state changes are registered one cycle after rx_valid (latency 1).
- The timer is cleared on every tx handshake and on every accepted rx byte. Timeout fires when timer == c_timeout-1.
- user_ack pulses in the same cycle the state enters USER_SEND.
- ready rises the cycle after the 0xFA following 0xF4. wheel is stable from then on.

## Test plan
- Standard mouse model: replies FA, AA 00, FA×6, FA then ID 00, FA → tx sequence FF F3 C8 F3 64 F3 50 F2 F4; ready=1, wheel=0. Stream bytes 08 05 FB → pkt_idx 0,1,2 with pkt_valid.
- Wheel model returns ID 03 → wheel=1. Bytes 09 01 02 FF → pkt_idx 0..3. Next byte 08 gives pkt_idx=0.
- Mouse answers FE once to the second F3 → F3 is resent once, init completes, retry count stays 0.
- Mouse silent → after 3×c_timeout (for c_retries=3), fail=1, ready=0, and tx_valid stays 0.
- Stream resync:
  - Byte 00 at pkt_idx=0 is dropped with no pkt_valid.
  - Byte 08 followed by silence longer than c_gap: the next byte 18 appears at pkt_idx=0.
- user_req with cmd E9 raised mid-packet → no grant until the packet completes. Then user_ack, tx E9, mouse replies FA → user_resp=FA strobed with no pkt_valid. Reset asserted during USER_SEND → tx restarts with FF.
